exec_dispatch: RTL and testbench

//  Initiator side of the execution-unit start/Done handshake. Accepts one opcode per

---
 rtl/exec_dispatch.sv | 177 +++++++++++++++++
 tb/tb_exec_dispatch.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_dispatch.sv
// Instruction dispatcher: decodes an opcode, starts one execution unit and waits for its Done.
// Handles halt, illegal-opcode and watchdog faults; the optional retire counter is built under DISPATCH_STATS_EN.
module exec_dispatch #(
    parameter int NUM_UNITS = 4,
    parameter int OPC_W     = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 instr_valid,
    input  logic [OPC_W-1:0]     opcode,
    output logic                 instr_ack,
    output logic [NUM_UNITS-1:0] unit_start,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 busy,
    output logic                 retire,
    output logic                 halted,
    output logic                 fault,
    output logic [1:0]           fault_code,
    input  logic                 fault_clr,
    output logic [15:0]          retire_cnt
);

    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [OPC_W-1:0] HALT_OPC = {OPC_W{1'b1}};
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_START,
        S_WAIT,
        S_RETIRE,
        S_HALT,
        S_FAULT
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ILLEGAL = 2'b01,
        FC_TIMEOUT = 2'b10
    } fault_code_e;

    state_e               state_q, state_d;
    logic [OPC_W-1:0]     opcode_q, opcode_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           timer_q, timer_d;
    fault_code_e          fault_code_q, fault_code_d;

    logic                 instr_ack_q, instr_ack_d;
    logic [NUM_UNITS-1:0] unit_start_q, unit_start_d;
    logic                 busy_q, busy_d;
    logic                 retire_q, retire_d;
    logic                 halted_q, halted_d;
    logic                 fault_q, fault_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
        state_d      = state_q;
        opcode_d     = opcode_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        fault_code_d = fault_code_q;

        case (state_q)
            S_IDLE: begin
                if (run && instr_valid) begin
                    opcode_d = opcode;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (int'(opcode_q) < NUM_UNITS) begin
                    idx_d   = IDX_W'(opcode_q);
                    state_d = S_START;
                end else if (opcode_q == HALT_OPC) begin
                    state_d = S_HALT;
                end else begin
                    fault_code_d = FC_ILLEGAL;
                    state_d      = S_FAULT;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
                // Done on the same edge as the last allowed cycle still retires.
                if (unit_done[idx_q]) begin
                    state_d = S_RETIRE;
                end else if (timer_q == TIMER_LAST) begin
                    fault_code_d = FC_TIMEOUT;
                    state_d      = S_FAULT;
                end
            end
            S_RETIRE: state_d = S_IDLE;
            S_HALT:   state_d = S_HALT;
            S_FAULT: begin
                if (fault_clr) begin
                    fault_code_d = FC_NONE;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with the state register.
        instr_ack_d  = (state_d == S_DECODE);
        unit_start_d = (state_d == S_START) ? (NUM_UNITS'(1) << idx_d) : '0;
        busy_d       = (state_d == S_DECODE) || (state_d == S_START) ||
                       (state_d == S_WAIT)   || (state_d == S_RETIRE);
        retire_d     = (state_d == S_RETIRE);
        halted_d     = (state_d == S_HALT);
        fault_d      = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            fault_code_q <= FC_NONE;
            instr_ack_q  <= 1'b0;
            unit_start_q <= '0;
            busy_q       <= 1'b0;
            retire_q     <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            fault_code_q <= fault_code_d;
            instr_ack_q  <= instr_ack_d;
            unit_start_q <= unit_start_d;
            busy_q       <= busy_d;
            retire_q     <= retire_d;
            halted_q     <= halted_d;
            fault_q      <= fault_d;
        end
    end

    assign instr_ack  = instr_ack_q;
    assign unit_start = unit_start_q;
    assign busy       = busy_q;
    assign retire     = retire_q;
    assign halted     = halted_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

`ifdef DISPATCH_STATS_EN
    logic [15:0] retire_cnt_q, retire_cnt_d;

    // Counts alongside the retire pulse; wraps naturally and survives fault_clr.
    always_comb begin
        retire_cnt_d = retire_d ? retire_cnt_q + 16'd1 : retire_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_exec_dispatch.sv
// Self-checking bench for exec_dispatch: table of single-instruction vectors plus
// hand-written latency, back-to-back, timeout, halt, reset and counter sequences.
module tb_exec_dispatch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        instr_valid = 1'b0;
    logic        fault_clr = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic [3:0]  model_done = 4'h0;
    logic [3:0]  noise_done = 4'h0;
    logic [3:0]  unit_done;
    logic        instr_ack, busy, retire, halted, fault;
    logic [3:0]  unit_start;
    logic [1:0]  fault_code;
    logic [15:0] retire_cnt;

    assign unit_done = model_done | noise_done;

    int tests_run = 0;
    int tests_failed = 0;
    int start_seen = 0;
    int retire_seen = 0;
    int ack_seen = 0;
    int unit_delay[4];
    int cnt[4];
    logic [3:0] exp_q[$];

    typedef struct {
        logic [3:0] opc;
        int         delay;
        logic [3:0] exp_start;
        logic       exp_retire;
        logic [1:0] exp_fc;
    } vec_t;

    vec_t vecs[9];

    exec_dispatch dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .instr_ack  (instr_ack),
        .unit_start (unit_start),
        .unit_done  (unit_done),
        .busy       (busy),
        .retire     (retire),
        .halted     (halted),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_clr  (fault_clr),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Unit models: Done pulses for one cycle, unit_delay cycles after the start pulse (0 = never).
    always @(negedge clk) begin
        if (reset) begin
            model_done = 4'h0;
            for (int i = 0; i < 4; i++) cnt[i] = 0;
        end else begin
            model_done = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (cnt[i] != 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) model_done[i] = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (unit_start[i] && unit_delay[i] != 0) cnt[i] = unit_delay[i];
            end
        end
    end

    // Scoreboard: each observed start pulse is matched against the next expected one-hot vector.
    always @(negedge clk) begin
        if (!reset) begin
            if (instr_ack) ack_seen++;
            if (retire) retire_seen++;
            if (unit_start != 4'h0) begin
                start_seen++;
                if (exp_q.size() == 0) check("unexpected_start", unit_start, 4'h0);
                else check("start_vector", unit_start, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cond(input string name, input int sel, input int budget);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            case (sel)
                0:       hit = instr_ack;
                1:       hit = retire | fault | halted;
                default: hit = (unit_start != 4'h0);
            endcase
        end
        check({name, "_reached"}, hit, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        instr_valid = 1'b0;
        opcode = 4'h0;
        fault_clr = 1'b0;
        noise_done = 4'h0;
        for (int i = 0; i < 4; i++) unit_delay[i] = 0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_delay(input int d);
        for (int i = 0; i < 4; i++) unit_delay[i] = d;
    endtask

    task automatic run_one(input logic [3:0] opc, input logic [3:0] exp_start);
        set_delay(2);
        exp_q.push_back(exp_start);
        run = 1'b1;
        instr_valid = 1'b1;
        opcode = opc;
        wait_cond("run_one_ack", 0, 10);
        instr_valid = 1'b0;
        wait_cond("run_one_done", 1, 40);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, s0, a0, waits;

        vecs[0] = '{4'h0, 4,  4'b0001, 1'b1, 2'b00};
        vecs[1] = '{4'h1, 1,  4'b0010, 1'b1, 2'b00};
        vecs[2] = '{4'h2, 7,  4'b0100, 1'b1, 2'b00};
        vecs[3] = '{4'h3, 15, 4'b1000, 1'b1, 2'b00};
        vecs[4] = '{4'h7, 3,  4'b0000, 1'b0, 2'b01};
        vecs[5] = '{4'h1, 0,  4'b0010, 1'b0, 2'b10};
        vecs[6] = '{4'h2, 16, 4'b0100, 1'b0, 2'b10};
        vecs[7] = '{4'h4, 2,  4'b0000, 1'b0, 2'b01};
        vecs[8] = '{4'h0, 2,  4'b0001, 1'b1, 2'b00};

        for (int i = 0; i < 4; i++) unit_delay[i] = 0;
        #2;
        check("reset_outputs", {instr_ack, unit_start, busy, retire, halted, fault, fault_code}, 11'h0);
        check("reset_retire_cnt", retire_cnt, 16'h0);
        do_reset();

        // Exact latency of a single instruction.
        set_delay(4);
        exp_q.push_back(4'b0001);
        tick();
        run = 1'b1;
        instr_valid = 1'b1;
        opcode = 4'h0;
        tick();
        check("lat_ack", {instr_ack, busy, unit_start}, {1'b1, 1'b1, 4'b0000});
        instr_valid = 1'b0;
        tick();
        check("lat_start", {instr_ack, unit_start}, {1'b0, 4'b0001});
        for (int k = 0; k < 4; k++) begin
            tick();
            check("lat_wait", {retire, unit_start, busy}, {1'b0, 4'b0000, 1'b1});
        end
        tick();
        check("lat_retire", retire, 1'b1);
        tick();
        check("lat_idle", {busy, retire}, 2'b00);

        // Table of single instructions.
        for (int v = 0; v < 9; v++) begin
            r0 = retire_seen;
            s0 = start_seen;
            set_delay(vecs[v].delay);
            if (vecs[v].exp_start != 4'h0) exp_q.push_back(vecs[v].exp_start);
            run = 1'b1;
            instr_valid = 1'b1;
            opcode = vecs[v].opc;
            wait_cond("vec_ack", 0, 10);
            drive_step();
            instr_valid = 1'b0;
            wait_cond("vec_outcome", 1, 40);
            check("vec_retires", retire_seen - r0, {31'd0, vecs[v].exp_retire});
            check("vec_starts", start_seen - s0, {31'd0, vecs[v].exp_start != 4'h0});
            check("vec_fault_code", fault_code, vecs[v].exp_fc);
            check("vec_fault", fault, vecs[v].exp_fc != 2'b00);
            if (fault) begin
                drive_step();
                fault_clr = 1'b1;
                drive_step();
                fault_clr = 1'b0;
                tick();
                check("fault_cleared", {fault, fault_code, busy}, 4'h0);
            end else begin
                tick();
                check("idle_after_retire", busy, 1'b0);
            end
        end

        // Back-to-back opcodes with instr_valid held high.
        set_delay(2);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        r0 = retire_seen;
        s0 = start_seen;
        run = 1'b1;
        instr_valid = 1'b1;
        opcode = 4'h1;
        for (int k = 0; k < 3; k++) begin
            wait_cond("b2b_ack", 0, 20);
            if (k < 2) opcode = 4'(k + 2);
            else instr_valid = 1'b0;
        end
        for (int k = 0; k < 60 && (retire_seen - r0) < 3; k++) tick();
        check("b2b_retires", retire_seen - r0, 3);
        check("b2b_starts", start_seen - s0, 3);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Watchdog with Done raised only on the other units: exactly 15 WAIT cycles.
        set_delay(0);
        noise_done = 4'b1101;
        exp_q.push_back(4'b0010);
        instr_valid = 1'b1;
        opcode = 4'h1;
        wait_cond("to_start", 2, 10);
        instr_valid = 1'b0;
        waits = 0;
        for (int k = 0; k < 40 && !fault; k++) begin
            tick();
            if (busy && !retire && !instr_ack && unit_start == 4'h0) waits++;
        end
        check("to_wait_cycles", waits, 15);
        check("to_fault_code", {fault, fault_code}, 3'b110);
        noise_done = 4'h0;
        fault_clr = 1'b1;
        drive_step();
        fault_clr = 1'b0;
        tick();
        check("to_cleared", {fault, fault_code}, 3'b000);

        // run low blocks acceptance; dropping run mid-instruction does not abort.
        a0 = ack_seen;
        run = 1'b0;
        instr_valid = 1'b1;
        opcode = 4'h2;
        repeat (5) tick();
        check("run_gate_no_ack", ack_seen - a0, 0);
        check("run_gate_idle", busy, 1'b0);
        set_delay(3);
        exp_q.push_back(4'b0100);
        r0 = retire_seen;
        run = 1'b1;
        wait_cond("run_drop_ack", 0, 10);
        run = 1'b0;
        instr_valid = 1'b0;
        wait_cond("run_drop_done", 1, 40);
        check("run_drop_retired", retire_seen - r0, 1);

        // HALT is absorbing and cleared only by reset.
        run = 1'b1;
        instr_valid = 1'b1;
        opcode = 4'hF;
        wait_cond("halt_reached", 1, 20);
        a0 = ack_seen;
        opcode = 4'h0;
        repeat (10) tick();
        check("halt_no_ack", ack_seen - a0, 0);
        check("halt_state", {halted, busy, fault}, 3'b100);
        do_reset();
        tick();
        check("halt_cleared", halted, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        set_delay(0);
        exp_q.push_back(4'b0010);
        run = 1'b1;
        instr_valid = 1'b1;
        opcode = 4'h1;
        wait_cond("rst_start", 2, 10);
        instr_valid = 1'b0;
        repeat (3) tick();
        check("rst_busy_before", busy, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_outputs", {instr_ack, unit_start, busy, retire, halted, fault, fault_code}, 11'h0);
        do_reset();

        // Retire counter.
        run_one(4'h0, 4'b0001);
        run_one(4'h1, 4'b0010);
        run_one(4'h3, 4'b1000);
`ifdef DISPATCH_STATS_EN
        check("stats_three", retire_cnt, 16'd3);
        dut.retire_cnt_q = 16'hFFFF;
        run_one(4'h2, 4'b0100);
        check("stats_wrap", retire_cnt, 16'h0000);
`else
        check("stats_tied_off", retire_cnt, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
